decode_issue_stage: RTL and testbench
=====================================

# decode_issue_stage

Instruction decode and issue stage sitting directly upstream of the register bank. It accepts 32-bit instructions from fetch over a valid/ready handshake and holds one instruction in a decode register. It drives the register bank read addresses from the held instruction and issues the decoded instruction, with its operands, downstream. A 32-entry busy scoreboard stalls issue on read-after-write and write-after-write hazards until writeback clears the pending destination.

## Interface
- No parameters. Fixed: 32 registers, 5-bit addresses, 32-bit data.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset), synchronous release.
- inValid  in  1  fetch presents an instruction.
- inReady  out  1  stage can accept this cycle.
- inInstr  in  32  instruction word.
- flush  in  1  discard the held instruction; scoreboard untouched.
- regAddr_1  out  5  register bank read address 1 = held rs.
- regAddr_2  out  5  register bank read address 2 = held rt.
- regReadData_1  in  32  register bank read data 1, combinational.
- regReadData_2  in  32  register bank read data 2, combinational.
- outValid  out  1  decoded instruction available downstream.
- outReady  in  1  downstream accepts.
- outOpcode  out  6  instr[31:26].
- outFunct  out  6  instr[5:0].
- outOpA  out  32  regReadData_1 passed through.
- outOpB  out  32  regReadData_2 passed through.
- outImm  out  32  sign-extended instr[15:0].
- outDst  out  5  destination register; 0 when outWrites = 0.
- outWrites  out  1  instruction writes a register.
- wbValid  in  1  writeback of wbAddr completes this cycle.
- wbAddr  in  5  register being written back.

## Operation
- Fields: rs = [25:21], rt = [20:16], rd = [15:11].
- Decode:
  - Opcode 0x00 (R-type): reads rs and rt; writes rd.
  - 0x2B (store) and 0x04 (beq): read rs and rt; no write.
  - All other opcodes: read rs only; write rt. rt is still driven on regAddr_2, but its busy bit is ignored.
- outWrites = 0 whenever the computed destination is r0.
- Held state: hValid and hInstr.
- Accept: inValid && inReady loads hInstr and sets hValid.
- inReady = !hValid || (outValid && outReady).
- Back-to-back accept and issue is allowed in the same cycle.
- Hazard: any of the following is busy:
  - busy[rs], or busy[rt] when rt is read;
  - busy[dst] when outWrites = 1.
- busy[0] is hard-wired to 0.
- outValid = hValid && !hazard && !flush.
- Issue: outValid && outReady sets busy[outDst] when outWrites = 1, and clears hValid unless a new instruction is accepted in the same cycle.
- Writeback: wbValid clears busy[wbAddr] at the clock edge. There is no bypass: a stalled consumer issues at the earliest the cycle after wbValid.
- Set and clear of the same register in the same cycle: set wins.
- flush:
  - Clears hValid at the edge and forces outValid = 0 that cycle.
  - inReady = 1 during flush.
  - An instruction accepted in a flush cycle is discarded.
- wbValid for a register that is not busy has no effect.
- Decode outputs are combinational from hInstr and hold their value while stalled.

## Timing
- Reset values: hValid = 0, hInstr = 0, busy = 0.
- Outputs in reset: outValid = 0, inReady = 1, regAddr_1 = regAddr_2 = 0, outDst = 0, outWrites = 0, outImm = 0.
- Reset asserted mid-operation drops the held instruction and the scoreboard immediately, without waiting for a clock edge.
- Latency: accept at edge N gives outValid during cycle N+1 if there is no hazard.
- Throughput: 1 instruction/cycle when hazard-free and outReady = 1.
- Stall: while outValid && !outReady, all out* signals are stable.
- A dependent instruction right after its producer stalls until the cycle following the producer's wbValid.

## Test plan
- Reset: rst = 0 mid-stream with hValid = 1 and busy[5] = 1 -> outValid = 0 and inReady = 1 immediately. After release, an instruction reading r5 issues without stall.
- Throughput: three independent R-type instructions back-to-back with outReady = 1 -> outValid on three consecutive cycles. regAddr_1/2 match each rs/rt (e.g. 28/30).
- RAW: R-type writing r28, then a consumer reading rs = 28. wbValid for r28 is given 4 cycles after issue -> consumer outValid = 0 for those cycles and rises the cycle after wbValid.
- Same-edge set/clear: issue of a new r7 writer in the same cycle as wbValid with wbAddr = 7 -> busy[7] remains 1. A following reader of r7 stalls.
- r0 and decode: R-type with rd = 0 -> outWrites = 0 and no stall on a subsequent r0 reader. I-type with imm = 0x8000 -> outImm = 0xFFFF8000, outDst = rt.
- Backpressure and flush: outReady = 0 for 3 cycles -> out* stable and inReady = 0. Then flush = 1 -> held instruction dropped, no busy bit set, inReady = 1.

Source files
------------

// File: rtl/decode_issue_stage_if.sv
// -----------------------------------------------------------------------------
// decode_issue_stage_if
//   Bundles every non-clock signal of the decode/issue stage: the fetch
//   handshake, flush, register bank read port, downstream issue bus and the
//   writeback notification.
//   Modports:
//     slave  - the decode/issue stage itself
//     master - the environment around it (fetch, register bank, execute, wb)
// -----------------------------------------------------------------------------
interface decode_issue_stage_if;
  // Fetch side
  logic        inValid;
  logic        inReady;
  logic [31:0] inInstr;
  logic        flush;
  // Register bank read port
  logic [4:0]  regAddr_1;
  logic [4:0]  regAddr_2;
  logic [31:0] regReadData_1;
  logic [31:0] regReadData_2;
  // Downstream issue bus
  logic        outValid;
  logic        outReady;
  logic [5:0]  outOpcode;
  logic [5:0]  outFunct;
  logic [31:0] outOpA;
  logic [31:0] outOpB;
  logic [31:0] outImm;
  logic [4:0]  outDst;
  logic        outWrites;
  // Writeback notification
  logic        wbValid;
  logic [4:0]  wbAddr;

  modport slave (
    input  inValid, inInstr, flush,
    input  regReadData_1, regReadData_2,
    input  outReady,
    input  wbValid, wbAddr,
    output inReady,
    output regAddr_1, regAddr_2,
    output outValid, outOpcode, outFunct, outOpA, outOpB, outImm,
    output outDst, outWrites
  );

  modport master (
    output inValid, inInstr, flush,
    output regReadData_1, regReadData_2,
    output outReady,
    output wbValid, wbAddr,
    input  inReady,
    input  regAddr_1, regAddr_2,
    input  outValid, outOpcode, outFunct, outOpA, outOpB, outImm,
    input  outDst, outWrites
  );
endinterface

// File: rtl/decode_issue_stage.sv
// -----------------------------------------------------------------------------
// decode_issue_stage
//   Holds one fetched instruction, drives the register bank read addresses
//   from it, decodes it and issues it downstream together with its operands.
//   A 32-entry busy scoreboard stalls issue on RAW and WAW hazards until the
//   pending destination is written back.
//   Ports:
//     clk - rising-edge clock
//     rst - asynchronous active-low reset (release expected synchronous)
//     bus - decode_issue_stage_if.slave: fetch handshake, flush, register
//           bank read port, issue bus, writeback notification
// -----------------------------------------------------------------------------
module decode_issue_stage (
  input  logic                  clk,
  input  logic                  rst,
  decode_issue_stage_if.slave   bus
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_STORE = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // How an opcode uses its register fields.
  typedef enum logic [1:0] {
    CLS_RTYPE,    // reads rs, rt; writes rd
    CLS_NOWRITE,  // reads rs, rt; writes nothing
    CLS_IMM       // reads rs; writes rt
  } instr_class_e;

  // Held instruction and scoreboard
  logic        r_h_valid;
  logic [31:0] r_h_instr;
  logic [31:0] r_busy;     // bit 0 is always 0 so r0 never stalls

  // Decode
  logic [5:0]   w_opcode;
  logic [4:0]   w_rs;
  logic [4:0]   w_rt;
  logic [4:0]   w_rd;
  instr_class_e w_class;
  logic         w_reads_rt;
  logic [4:0]   w_dst_raw;
  logic         w_writes;
  logic [4:0]   w_dst;

  // Control
  logic        w_hazard;
  logic        w_out_valid;
  logic        w_issue;
  logic        w_in_ready;
  logic        w_accept;
  logic [31:0] w_busy_clr;
  logic [31:0] w_busy_set;
  logic [31:0] w_busy_next;

  assign w_opcode = r_h_instr[31:26];
  assign w_rs     = r_h_instr[25:21];
  assign w_rt     = r_h_instr[20:16];
  assign w_rd     = r_h_instr[15:11];

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_class   = CLS_IMM;
    w_dst_raw = w_rt;
    case (w_opcode)
      OP_RTYPE: begin
        w_class   = CLS_RTYPE;
        w_dst_raw = w_rd;
      end
      OP_STORE, OP_BEQ: begin
        w_class   = CLS_NOWRITE;
        w_dst_raw = 5'd0;
      end
      default: ;
    endcase
  end

  assign w_reads_rt = (w_class != CLS_IMM);
  // A write to r0 is architecturally a no-op, so it is not a write at all.
  assign w_writes   = (w_class != CLS_NOWRITE) && (w_dst_raw != 5'd0);
  assign w_dst      = w_writes ? w_dst_raw : 5'd0;

  // An I-type's rt is a destination, not a source: only its WAW term applies.
  assign w_hazard = r_busy[w_rs]
                  | (w_reads_rt & r_busy[w_rt])
                  | (w_writes   & r_busy[w_dst]);

  assign w_out_valid = r_h_valid & ~w_hazard & ~bus.flush;
  assign w_issue     = w_out_valid & bus.outReady;
  // Flush empties the stage, so it can always take a new word (then dropped).
  assign w_in_ready  = ~r_h_valid | w_issue | bus.flush;
  assign w_accept    = bus.inValid & w_in_ready;

  // Clear is applied before set so an issue to the register being written
  // back in the same cycle leaves it busy.
  assign w_busy_clr  = bus.wbValid ? (32'd1 << bus.wbAddr) : 32'd0;
  assign w_busy_set  = (w_issue & w_writes) ? (32'd1 << w_dst) : 32'd0;
  assign w_busy_next = (r_busy & ~w_busy_clr) | w_busy_set;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_valid <= 1'b0;
      r_h_instr <= 32'd0;
      // NOTE: the scoreboard is reset as a whole; stale busy bits would
      // otherwise stall the first instructions after reset forever.
      r_busy    <= 32'd0;
    end else begin
      r_busy <= {w_busy_next[31:1], 1'b0};
      if (bus.flush) begin
        r_h_valid <= 1'b0;
      end else if (w_accept) begin
        r_h_valid <= 1'b1;
        r_h_instr <= bus.inInstr;
      end else if (w_issue) begin
        r_h_valid <= 1'b0;
      end
    end
  end

  assign bus.inReady   = w_in_ready;
  assign bus.regAddr_1 = w_rs;
  assign bus.regAddr_2 = w_rt;
  assign bus.outValid  = w_out_valid;
  assign bus.outOpcode = w_opcode;
  assign bus.outFunct  = r_h_instr[5:0];
  assign bus.outOpA    = bus.regReadData_1;
  assign bus.outOpB    = bus.regReadData_2;
  assign bus.outImm    = {{16{r_h_instr[15]}}, r_h_instr[15:0]};
  assign bus.outDst    = w_dst;
  assign bus.outWrites = w_writes;

endmodule

// File: tb/tb_decode_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_issue_stage
//   Directed bench for decode_issue_stage. Every accepted instruction pushes
//   its expected decode onto a queue; a monitor pops and compares whenever the
//   stage issues. Timing of outValid/inReady is checked inline per step.
// -----------------------------------------------------------------------------
module tb_decode_issue_stage;

  logic clk;
  logic rst;

  decode_issue_stage_if bus ();

  decode_issue_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [4:0]  dst;
    logic        wr;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Register bank contents: a recognisable function of the address.
  function automatic logic [31:0] rb(input logic [4:0] addr);
    return {16'hA5A5, 3'b000, addr, 3'b000, addr};
  endfunction

  assign bus.regReadData_1 = rb(bus.regAddr_1);
  assign bus.regReadData_2 = rb(bus.regAddr_2);

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    e.op  = ins[31:26];
    e.fn  = ins[5:0];
    e.ra1 = ins[25:21];
    e.ra2 = ins[20:16];
    e.a   = rb(ins[25:21]);
    e.b   = rb(ins[20:16]);
    e.imm = {{16{ins[15]}}, ins[15:0]};
    if (e.op == 6'h00)                       e.dst = ins[15:11];
    else if (e.op == 6'h2B || e.op == 6'h04) e.dst = 5'd0;
    else                                     e.dst = ins[20:16];
    e.wr = (e.dst != 5'd0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction that must be accepted at the coming edge.
  task automatic drive(input logic [31:0] ins);
    bus.inValid = 1'b1;
    bus.inInstr = ins;
    #1;
    check("in_ready_on_drive", 32'(bus.inReady), 32'd1);
    q.push_back(model(ins));
  endtask

  task automatic idle();
    bus.inValid = 1'b0;
  endtask

  task automatic wb(input logic [4:0] addr);
    bus.wbValid = 1'b1;
    bus.wbAddr  = addr;
    tick();
    bus.wbValid = 1'b0;
  endtask

  // Scoreboard monitor: compare each issued instruction with its expectation.
  always @(negedge clk) begin
    if (rst && bus.outValid && bus.outReady) begin
      if (q.size() == 0) begin
        check("sb_issue_without_expectation", 32'(q.size()), 32'd1);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sb_opcode",    32'(bus.outOpcode), 32'(e.op));
        check("sb_funct",     32'(bus.outFunct),  32'(e.fn));
        check("sb_regaddr1",  32'(bus.regAddr_1), 32'(e.ra1));
        check("sb_regaddr2",  32'(bus.regAddr_2), 32'(e.ra2));
        check("sb_opa",       bus.outOpA,         e.a);
        check("sb_opb",       bus.outOpB,         e.b);
        check("sb_imm",       bus.outImm,         e.imm);
        check("sb_dst",       32'(bus.outDst),    32'(e.dst));
        check("sb_writes",    32'(bus.outWrites), 32'(e.wr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b0;
    bus.inValid  = 1'b0;
    bus.inInstr  = 32'd0;
    bus.flush    = 1'b0;
    bus.outReady = 1'b1;
    bus.wbValid  = 1'b0;
    bus.wbAddr   = 5'd0;

    // ---------------- Reset values ----------------
    #2;
    check("rst_out_valid",  32'(bus.outValid),  32'd0);
    check("rst_in_ready",   32'(bus.inReady),   32'd1);
    check("rst_regaddr1",   32'(bus.regAddr_1), 32'd0);
    check("rst_regaddr2",   32'(bus.regAddr_2), 32'd0);
    check("rst_out_dst",    32'(bus.outDst),    32'd0);
    check("rst_out_writes", 32'(bus.outWrites), 32'd0);
    check("rst_out_imm",    bus.outImm,         32'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();

    // ---------------- Throughput: three independent R-types ----------------
    drive(rtype(5'd28, 5'd30, 5'd1, 6'h20));
    tick();
    check("tp0_valid", 32'(bus.outValid),  32'd1);
    check("tp0_ra1",   32'(bus.regAddr_1), 32'd28);
    check("tp0_ra2",   32'(bus.regAddr_2), 32'd30);
    drive(rtype(5'd2, 5'd3, 5'd4, 6'h22));
    tick();
    check("tp1_valid", 32'(bus.outValid),  32'd1);
    check("tp1_ra1",   32'(bus.regAddr_1), 32'd2);
    drive(rtype(5'd5, 5'd6, 5'd8, 6'h24));
    tick();
    idle();
    #1;
    check("tp2_valid", 32'(bus.outValid),  32'd1);
    check("tp2_ra2",   32'(bus.regAddr_2), 32'd6);
    tick();
    check("tp_drained", 32'(bus.outValid), 32'd0);
    wb(5'd1);
    wb(5'd4);
    wb(5'd8);

    // ---------------- RAW on r28 ----------------
    drive(rtype(5'd10, 5'd11, 5'd28, 6'h20));
    tick();
    check("raw_producer_valid", 32'(bus.outValid), 32'd1);
    drive(rtype(5'd28, 5'd12, 5'd13, 6'h21));
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      #1;
      check("raw_stall_valid", 32'(bus.outValid), 32'd0);
      check("raw_stall_ready", 32'(bus.inReady),  32'd0);
      tick();
    end
    bus.wbValid = 1'b1;
    bus.wbAddr  = 5'd28;
    #1;
    check("raw_no_bypass", 32'(bus.outValid), 32'd0);
    tick();
    bus.wbValid = 1'b0;
    #1;
    check("raw_release_valid", 32'(bus.outValid), 32'd1);
    check("raw_release_dst",   32'(bus.outDst),   32'd13);
    tick();
    wb(5'd13);

    // ---------------- Same-edge set/clear on r7 ----------------
    drive(rtype(5'd3, 5'd4, 5'd7, 6'h25));
    tick();
    bus.wbValid = 1'b1;
    bus.wbAddr  = 5'd7;
    check("sc_writer_valid", 32'(bus.outValid), 32'd1);
    check("sc_writer_dst",   32'(bus.outDst),   32'd7);
    drive(rtype(5'd7, 5'd0, 5'd9, 6'h20));
    tick();
    bus.wbValid = 1'b0;
    idle();
    #1;
    check("sc_reader_stall0", 32'(bus.outValid), 32'd0);
    tick();
    check("sc_reader_stall1", 32'(bus.outValid), 32'd0);
    wb(5'd7);
    check("sc_reader_release", 32'(bus.outValid), 32'd1);
    tick();
    wb(5'd9);

    // ---------------- r0 handling and immediate decode ----------------
    drive(rtype(5'd1, 5'd2, 5'd0, 6'h20));
    tick();
    check("r0_valid",  32'(bus.outValid),  32'd1);
    check("r0_writes", 32'(bus.outWrites), 32'd0);
    check("r0_dst",    32'(bus.outDst),    32'd0);
    drive(rtype(5'd0, 5'd0, 5'd3, 6'h20));
    tick();
    check("r0_reader_no_stall", 32'(bus.outValid), 32'd1);
    drive(itype(6'h23, 5'd4, 5'd9, 16'h8000));
    tick();
    check("imm_valid",  32'(bus.outValid),  32'd1);
    check("imm_value",  bus.outImm,         32'hFFFF8000);
    check("imm_dst",    32'(bus.outDst),    32'd9);
    check("imm_writes", 32'(bus.outWrites), 32'd1);
    // Store reading rt = 9 must wait for r9.
    drive(itype(6'h2B, 5'd0, 5'd9, 16'h0004));
    tick();
    idle();
    #1;
    check("st_rt_stall", 32'(bus.outValid),  32'd0);
    check("st_writes",   32'(bus.outWrites), 32'd0);
    tick();
    bus.wbValid = 1'b1;
    bus.wbAddr  = 5'd9;
    #1;
    check("st_wb_cycle", 32'(bus.outValid), 32'd0);
    tick();
    bus.wbValid = 1'b0;
    #1;
    check("st_release", 32'(bus.outValid), 32'd1);
    tick();
    wb(5'd3);

    // ---------------- Backpressure then flush ----------------
    bus.outReady = 1'b0;
    drive(rtype(5'd12, 5'd13, 5'd14, 6'h2A));
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_valid", 32'(bus.outValid),  32'd1);
      check("bp_ready", 32'(bus.inReady),   32'd0);
      check("bp_dst",   32'(bus.outDst),    32'd14);
      check("bp_funct", 32'(bus.outFunct),  32'h2A);
      check("bp_opa",   bus.outOpA,         rb(5'd12));
      tick();
    end
    bus.flush   = 1'b1;
    bus.inValid = 1'b1;
    bus.inInstr = rtype(5'd1, 5'd1, 5'd16, 6'h20);
    #1;
    check("fl_valid", 32'(bus.outValid), 32'd0);
    check("fl_ready", 32'(bus.inReady),  32'd1);
    tick();
    bus.flush = 1'b0;
    idle();
    #1;
    check("fl_dropped", 32'(bus.outValid), 32'd0);
    void'(q.pop_back());
    bus.outReady = 1'b1;
    drive(rtype(5'd14, 5'd0, 5'd15, 6'h20));
    tick();
    idle();
    #1;
    check("fl_no_busy_set", 32'(bus.outValid), 32'd1);
    tick();
    wb(5'd15);

    // ---------------- Asynchronous reset mid-stream ----------------
    drive(rtype(5'd1, 5'd2, 5'd5, 6'h20));
    tick();
    drive(rtype(5'd5, 5'd0, 5'd20, 6'h20));
    tick();
    idle();
    #1;
    check("ar_pre_stall", 32'(bus.outValid), 32'd0);
    check("ar_pre_ready", 32'(bus.inReady),  32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("ar_valid", 32'(bus.outValid), 32'd0);
    check("ar_ready", 32'(bus.inReady),  32'd1);
    check("ar_dst",   32'(bus.outDst),   32'd0);
    void'(q.pop_back());
    tick();
    rst = 1'b1;
    tick();
    drive(rtype(5'd5, 5'd0, 5'd20, 6'h20));
    tick();
    idle();
    #1;
    check("ar_r5_no_stall", 32'(bus.outValid), 32'd1);
    tick();
    wb(5'd20);

    tick();
    tick();
    check("sb_all_issued", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
